fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register; feeds the decode stage whose opcode drives the control unit.
//  Holds the PC and selects next PC from PC+4, taken-branch target (from EX) or jump target (from ID).
//  Squashes wrong-path fetches; honours decode stall and flush.
//  No branch delay slot.
// PARAMETERS
//  PC_WIDTH   32            width of PC, addresses and instruction words
//  RESET_PC   32'h0000_0000 PC loaded on reset
//  NOP_INSTR  32'h0000_0000 bubble word (sll $0,$0,0; opcode 6'b000000)
// PORTS
//  clk             in   1   rising-edge clock
//  rst_n           in   1   synchronous, active-low reset
//  stall           in   1   hazard stall: hold PC and IF/ID contents
//  flush           in   1   replace IF/ID contents with bubble next edge
//  branch_taken    in   1   EX-stage Branch & zero; redirect to branch_target
//  branch_target   in   32  byte address of taken branch
//  jump            in   1   ID-stage jump decode for instr held in IF/ID
//  imem_addr       out  32  instruction memory address (= pc, combinational)
//  imem_rdata      in   32  instruction word at imem_addr (async read)
//  pc              out  32  current fetch PC
//  if_id_instr     out  32  registered instruction for decode
//  if_id_pc_plus4  out  32  registered PC+4 of that instruction
//  if_id_valid     out  1   IF/ID holds a real (non-bubble) instruction
//  opcode          out  6   if_id_instr[31:26], to control unit
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc_plus4=0, if_id_valid=0.
//    Overrides all other inputs, including mid-redirect.
//  - Latency: word at pc appears on if_id_instr one edge later; imem_addr tracks pc same cycle.
//  - Next-state priority each edge:
//    reset > branch_taken > (jump & if_id_valid) > stall > normal.
//  - branch_taken: pc<=branch_target & ~3; IF/ID<=bubble (valid=0). Overrides stall and flush.
//  - jump (only if if_id_valid=1): pc<={if_id_pc_plus4[31:28], if_id_instr[25:0], 2'b00}; IF/ID<=bubble.
//    jump with if_id_valid=0 is ignored.
//  - stall (no redirect): pc, if_id_* held unchanged; if also flush: pc held, IF/ID<=bubble.
//  - flush alone: pc<=pc+4; IF/ID<=bubble.
//  - normal: pc<=pc+4; if_id_instr<=imem_rdata; if_id_pc_plus4<=pc+4; if_id_valid<=1.
//  - Arithmetic: pc+4 modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000 wraps silently).
//    pc[1:0] always 00.
//  - Bubble: if_id_instr=NOP_INSTR, if_id_pc_plus4=0, if_id_valid=0.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs perf_fetch[31:0], perf_stall[31:0], perf_squash[31:0].
//    perf_fetch: +1 per normal-path load. perf_stall: +1 per held cycle.
//    perf_squash: +1 per branch or jump redirect.
//    All three reset to 0 and wrap at 2^32.
//  Undefined: ports and counters absent; remaining behaviour identical.
// TESTING
//  1. Reset, imem word=addr>>2, 4 cycles free-run
//     -> pc 0,4,8,12,16; if_id_instr 0,1,2,3; if_id_valid 0 then 1.
//  2. stall high 3 cycles at pc=8 -> pc=8, if_id_instr=1 held;
//     release -> pc=12 next edge.
//  3. branch_taken=1, branch_target=0x40 while stall=1
//     -> next pc=0x40, if_id_valid=0; then if_id_instr=0x10.
//  4. IF/ID holds 0x0800_0010 (j), if_id_pc_plus4=0x8, jump=1
//     -> pc=0x40, bubble; same with branch_taken -> branch target wins.
//  5. pc forced near top: pc=0xFFFF_FFFC -> next pc=0, no X.
//     rst_n=0 during redirect -> pc=RESET_PC, valid=0.
//  6. FETCH_PERF_CNT_EN: run scenarios 1-4 -> counters equal counted fetches, stalls, squashes; all 0 after reset.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage with PC register and IF/ID pipeline register.
// Optional counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter int                  PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter logic [PC_WIDTH-1:0] NOP_INSTR = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                flush,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                jump,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [PC_WIDTH-1:0] imem_rdata,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] if_id_instr,
    output logic [PC_WIDTH-1:0] if_id_pc_plus4,
    output logic                if_id_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]         perf_fetch,
    output logic [31:0]         perf_stall,
    output logic [31:0]         perf_squash,
`endif
    output logic [5:0]          opcode
);

    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] jump_target;
    logic [PC_WIDTH-1:0] pc_n;
    logic [PC_WIDTH-1:0] instr_n;
    logic [PC_WIDTH-1:0] p4_n;
    logic                valid_n;
    logic                do_branch;
    logic                do_jump;
    logic                do_hold;
    logic                do_load;

    assign imem_addr = pc;
    assign opcode    = if_id_instr[31:26];
    assign pc_plus4  = pc + PC_WIDTH'(4);

    // Pseudo-direct target formed from the jump held in IF/ID
    assign jump_target = {if_id_pc_plus4[PC_WIDTH-1 -: 4],
                          if_id_instr[25:0], 2'b00};

    // Priority decode: branch beats jump beats stall beats normal
    assign do_branch = branch_taken;
    assign do_jump   = jump & if_id_valid & ~branch_taken;
    assign do_hold   = stall & ~do_branch & ~do_jump;
    assign do_load   = ~stall & ~flush & ~do_branch & ~do_jump;

    // Next PC and IF/ID contents
    always_comb begin
        pc_n    = pc;
        instr_n = if_id_instr;
        p4_n    = if_id_pc_plus4;
        valid_n = if_id_valid;
        if (do_branch) begin
            pc_n    = {branch_target[PC_WIDTH-1:2], 2'b00};
            instr_n = NOP_INSTR;
            p4_n    = '0;
            valid_n = 1'b0;
        end else if (do_jump) begin
            pc_n    = jump_target;
            instr_n = NOP_INSTR;
            p4_n    = '0;
            valid_n = 1'b0;
        end else if (do_hold) begin
            if (flush) begin
                instr_n = NOP_INSTR;
                p4_n    = '0;
                valid_n = 1'b0;
            end
        end else if (flush) begin
            pc_n    = pc_plus4;
            instr_n = NOP_INSTR;
            p4_n    = '0;
            valid_n = 1'b0;
        end else begin
            pc_n    = pc_plus4;
            instr_n = imem_rdata;
            p4_n    = pc_plus4;
            valid_n = 1'b1;
        end
    end

    // PC and IF/ID register update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
        end else begin
            pc             <= pc_n;
            if_id_instr    <= instr_n;
            if_id_pc_plus4 <= p4_n;
            if_id_valid    <= valid_n;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Event counters: loads, held cycles, redirects
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch  <= '0;
            perf_stall  <= '0;
            perf_squash <= '0;
        end else begin
            if (do_load)
                perf_fetch <= perf_fetch + 32'd1;
            if (do_hold)
                perf_stall <= perf_stall + 32'd1;
            if (do_branch || do_jump)
                perf_squash <= perf_squash + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: free-run, stall, flush,
// branch/jump redirects, PC wrap and reset override.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [5:0]  opcode;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
    logic [31:0] perf_squash;
`endif

    logic        ovr;
    logic [31:0] ovr_word;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Instruction memory: word index of the address, or an override word
    assign imem_rdata = ovr ? ovr_word : {2'b00, imem_addr[31:2]};

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .pc             (pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch     (perf_fetch),
        .perf_stall     (perf_stall),
        .perf_squash    (perf_squash),
`endif
        .opcode         (opcode)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input string tag, input logic [31:0] epc,
                      input logic [31:0] ei, input logic [31:0] ep4,
                      input logic ev);
        chk({tag, ".pc"}, pc, epc);
        chk({tag, ".instr"}, if_id_instr, ei);
        chk({tag, ".pc4"}, if_id_pc_plus4, ep4);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, ev});
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        branch_taken = 1'b0; branch_target = '0; jump = 1'b0;
        ovr = 1'b0; ovr_word = '0;

        // Reset then free-run 4 cycles
        step();
        st("rst", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("rst.addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst.pf", perf_fetch, 0);
        chk("rst.ps", perf_stall, 0);
        chk("rst.pq", perf_squash, 0);
`endif
        rst_n = 1'b1;
        step(); st("run1", 32'h4, 32'h0, 32'h4, 1'b1);
        step(); st("run2", 32'h8, 32'h1, 32'h8, 1'b1);
        chk("run2.addr", imem_addr, 32'h8);
        step(); st("run3", 32'hC, 32'h2, 32'hC, 1'b1);
        step(); st("run4", 32'h10, 32'h3, 32'h10, 1'b1);

        // Back to pc=8, then stall 3 cycles
        rst_n = 1'b0; step();
        st("rst2", 32'h0, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b1; step(); step();
        stall = 1'b1;
        step(); st("stl1", 32'h8, 32'h1, 32'h8, 1'b1);
        step(); st("stl2", 32'h8, 32'h1, 32'h8, 1'b1);
        step(); st("stl3", 32'h8, 32'h1, 32'h8, 1'b1);
        stall = 1'b0;
        step(); st("rel", 32'hC, 32'h2, 32'hC, 1'b1);

        // Branch wins over stall
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
        step(); st("br", 32'h40, 32'h0, 32'h0, 1'b0);
        stall = 1'b0; branch_taken = 1'b0;
        step(); st("br2", 32'h44, 32'h10, 32'h44, 1'b1);

        // Flush alone, then stall with flush
        flush = 1'b1;
        step(); st("fl", 32'h48, 32'h0, 32'h0, 1'b0);
        flush = 1'b0;
        step(); st("fl2", 32'h4C, 32'h12, 32'h4C, 1'b1);
        stall = 1'b1; flush = 1'b1;
        step(); st("sfl", 32'h4C, 32'h0, 32'h0, 1'b0);
        stall = 1'b0; flush = 1'b0;

        // Jump ignored while IF/ID is a bubble
        jump = 1'b1;
        step(); st("jinv", 32'h50, 32'h13, 32'h50, 1'b1);
        jump = 1'b0;

        // Jump held in IF/ID with pc_plus4=8
        branch_taken = 1'b1; branch_target = 32'h4;
        step(); st("tob", 32'h4, 32'h0, 32'h0, 1'b0);
        branch_taken = 1'b0; ovr = 1'b1; ovr_word = 32'h0800_0010;
        step(); st("jld", 32'h8, 32'h0800_0010, 32'h8, 1'b1);
        chk("jld.op", {26'd0, opcode}, 32'h2);
        ovr = 1'b0; jump = 1'b1;
        step(); st("jmp", 32'h40, 32'h0, 32'h0, 1'b0);
        jump = 1'b0;

        // Branch beats a simultaneous valid jump
        branch_taken = 1'b1; branch_target = 32'h4;
        step();
        branch_taken = 1'b0; ovr = 1'b1;
        step(); st("jld2", 32'h8, 32'h0800_0010, 32'h8, 1'b1);
        ovr = 1'b0; jump = 1'b1;
        branch_taken = 1'b1; branch_target = 32'h103;
        step(); st("bwin", 32'h100, 32'h0, 32'h0, 1'b0);
        jump = 1'b0; branch_taken = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        // Since rst2: loads 2+1+1+1+1+1+1=8, holds 3+1=4, redirects 5
        chk("pf", perf_fetch, 32'd8);
        chk("ps", perf_stall, 32'd4);
        chk("pq", perf_squash, 32'd5);
`endif

        // PC wraps from the top of the address space
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
        step(); st("top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        branch_taken = 1'b0;
        step(); st("wrap", 32'h0, 32'h3FFF_FFFF, 32'h0, 1'b1);

        // Reset overrides a redirect
        rst_n = 1'b0; branch_taken = 1'b1; jump = 1'b1;
        branch_target = 32'h80;
        step(); st("rstr", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        chk("rstr.pf", perf_fetch, 0);
        chk("rstr.ps", perf_stall, 0);
        chk("rstr.pq", perf_squash, 0);
`endif
        rst_n = 1'b1; branch_taken = 1'b0; jump = 1'b0;
        step(); st("post", 32'h4, 32'h0, 32'h4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
